sram_port_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_pick.sv | 29 ++
 rtl/sram_port_arbiter.sv | 78 +++++++
 tb/tb_sram_port_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and helpers for the SRAM port arbiter.
package sram_arb_pkg;
    localparam int MAX_REQ = 8;
    localparam int SRAM_ADDR_WIDTH = 10;
    localparam int SRAM_DATA_WIDTH = 32;

    typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

    typedef struct packed {
        logic [SRAM_ADDR_WIDTH-1:0]   addr;
        logic                         we;
        logic [SRAM_DATA_WIDTH/8-1:0] be;
        logic [SRAM_DATA_WIDTH-1:0]   wdata;
    } sram_req_t;

    function automatic logic is_onehot0(logic [MAX_REQ-1:0] v);
        return (v & (v - 1'b1)) == '0;
    endfunction
endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: first requester found scanning upward from i_start (with wrap)
// wins; fixed priority is simply i_start = 0.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  req_idx_t           i_start,
    output logic [NUM_REQ-1:0] o_gnt,
    output req_idx_t           o_idx
);
    logic     w_found;
    req_idx_t w_cand;

    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        o_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = req_idx_t'((int'(i_start) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = w_cand;
            end
        end
        o_gnt = w_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << o_idx) : '0;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM RW port among NUM_REQ OBI-style requesters.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              req_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]              rvalid_o,
    output logic [NUM_REQ*DATA_WIDTH-1:0]   rdata_o,
    output logic                            ram_en_o,
    output logic                            ram_we_o,
    output logic [DATA_WIDTH/8-1:0]         ram_be_o,
    output logic [ADDR_WIDTH-1:0]           ram_addr_o,
    output logic [DATA_WIDTH-1:0]           ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]           ram_rdata_i
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    req_idx_t           w_start;
    req_idx_t           w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               r_rvalid;
    req_idx_t           r_rsp_owner;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    req_idx_t r_rr_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_rr_ptr <= '0;
        else if (|w_gnt)
            r_rr_ptr <= (w_idx == req_idx_t'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    sram_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req   (req_i),
        .i_start (w_start),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx)
    );

    assign gnt_o       = rst_ni ? w_gnt : '0;
    assign ram_en_o    = rst_ni & (|req_i);
    assign ram_we_o    = we_i[w_idx];
    assign ram_be_o    = be_i[w_idx*BE_WIDTH +: BE_WIDTH];
    assign ram_addr_o  = addr_i[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign ram_wdata_o = wdata_i[w_idx*DATA_WIDTH +: DATA_WIDTH];

    // One response bit plus its owner; the RAM answers exactly one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid    <= 1'b0;
            r_rsp_owner <= '0;
        end else begin
            r_rvalid <= |w_gnt;
            if (|w_gnt)
                r_rsp_owner <= w_idx;
        end
    end

    assign rvalid_o = r_rvalid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_rsp_owner) : '0;
    assign rdata_o  = {NUM_REQ{ram_rdata_i}};
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of grant, response routing and reset.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, gnt, we = '0, rvalid;
    logic [19:0] addr = '0;
    logic [7:0]  be = '0;
    logic [63:0] wdata = '0, rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata = '0;
    logic [31:0] mem [1024];
    int          n_chk = 0, n_fail = 0;
    logic [1:0]  exp_g;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_REQ(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h155] = 32'hDEADBEEF;
        mem[10'h3FF] = 32'hAABBCCDD;
        req = 2'b11;
        tick();
        tick();
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_en", 64'(ram_en), 64'h0);
        check("rst_rvalid", 64'(rvalid), 64'h0);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            check($sformatf("cont_gnt%0d", k), 64'(gnt), 64'(exp_g));
            check($sformatf("cont_onehot%0d", k), 64'(is_onehot0({6'b0, gnt})), 64'h1);
            check($sformatf("cont_en%0d", k), 64'(ram_en), 64'h1);
            tick();
            check($sformatf("cont_rvalid%0d", k), 64'(rvalid), 64'(exp_g));
        end
        req = 2'b00;
        #1;
        check("idle_gnt", 64'(gnt), 64'h0);
        check("idle_en", 64'(ram_en), 64'h0);
        tick();
        check("idle_rvalid", 64'(rvalid), 64'h0);

        req = 2'b01; addr[9:0] = 10'h155; we = 2'b00;
        #1;
        check("rd_gnt", 64'(gnt), 64'h1);
        check("rd_addr", 64'(ram_addr), 64'h155);
        check("rd_we", 64'(ram_we), 64'h0);
        tick();
        req = 2'b00;
        check("rd_rvalid", 64'(rvalid), 64'h1);
        check("rd_data", 64'(rdata[31:0]), 64'hDEADBEEF);

        addr = {10'h3FF, 10'h001}; we = 2'b10; be = 8'b0011_1111;
        wdata = {32'h12345678, 32'hCAFEF00D}; req = 2'b10;
        #1;
        check("wr_gnt", 64'(gnt), 64'h2);
        check("wr_we", 64'(ram_we), 64'h1);
        check("wr_be", 64'(ram_be), 64'h3);
        check("wr_addr", 64'(ram_addr), 64'h3FF);
        check("wr_data", 64'(ram_wdata), 64'h12345678);
        tick();
        check("wr_rvalid", 64'(rvalid), 64'h2);
        we = 2'b00;
        #1;
        check("rb_gnt", 64'(gnt), 64'h2);
        check("rb_we", 64'(ram_we), 64'h0);
        tick();
        req = 2'b00;
        check("rb_rvalid", 64'(rvalid), 64'h2);
        check("rb_data", 64'(rdata[63:32]), 64'hAABB5678);

        req = 2'b10;
        #1;
        check("mid_gnt", 64'(gnt), 64'h2);
        tick();
        req = 2'b00;
        check("mid_pending", 64'(rvalid), 64'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rvalid_drop", 64'(rvalid), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_no_spurious", 64'(rvalid), 64'h0);

        req = 2'b01;
        tick();
        req = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 2'b11;
        #1;
        check("ptr_reset_gnt", 64'(gnt), 64'h1);
        tick();
        req = 2'b00;
        check("ptr_reset_rvalid", 64'(rvalid), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
